// File: rtl/spin_sweep_controller_if.sv
// Link between the sweep controller and one Spin update cell.
// The controller presents a site, its four neighbours, an enable and a random word.
// The cell returns the new spin value combinationally in the same cycle.
interface spin_sweep_controller_if;
  logic        upd_spin;
  logic        upd_left;
  logic        upd_right;
  logic        upd_top;
  logic        upd_bottom;
  logic        upd_enable;
  logic [31:0] rand32;
  logic        upd_result;

  modport master (
    output upd_spin, upd_left, upd_right, upd_top, upd_bottom, upd_enable, rand32,
    input  upd_result
  );

  modport slave (
    input  upd_spin, upd_left, upd_right, upd_top, upd_bottom, upd_enable, rand32,
    output upd_result
  );
endinterface

// File: rtl/spin_sweep_controller.sv
// Checkerboard Metropolis sweep engine for a periodic WIDTHxHEIGHT Ising lattice.
// The lattice lives in flops. One site is offered to the Spin cell per RUN cycle,
// the returned spin is written back, and a running magnetization is kept.
module spin_sweep_controller #(
  parameter int          WIDTH  = 8,
  parameter int          HEIGHT = 8,
  parameter logic [31:0] SEED   = 32'hACE1_2025,
  parameter int          SW_W   = 16,
  localparam int         XW     = $clog2(WIDTH),
  localparam int         YW     = $clog2(HEIGHT),
  localparam int         MAG_W  = $clog2(WIDTH * HEIGHT) + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    init_up,
  input  logic [SW_W-1:0]         num_sweeps,
  output logic                    busy,
  output logic                    done,
  output logic [SW_W-1:0]         sweep_cnt,
  output logic signed [MAG_W-1:0] mag,
  input  logic [XW-1:0]           rd_x,
  input  logic [YW-1:0]           rd_y,
  output logic                    rd_spin,
  spin_sweep_controller_if.master upd
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0]            SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic signed [MAG_W-1:0] MAG_FULL = MAG_W'(WIDTH * HEIGHT);

  logic [1:0]                     state;
  logic [HEIGHT-1:0][WIDTH-1:0]   lat;
  logic [XW-1:0]                  x, x_nx, x_l, x_r;
  logic [YW-1:0]                  y, y_nx, y_t, y_b;
  logic                           ph, ph_nx;
  logic                           sweep_end;
  logic                           row_end;
  logic                           next_row_lsb;
  logic [XW:0]                    x_plus2;
  logic [SW_W-1:0]                nsw;
  logic [31:0]                    rng;
  logic                           run;
  logic                           cur;

  function automatic logic [31:0] xorshift32(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  assign run     = (state == S_RUN);
  assign busy    = (state == S_INIT) || run;
  assign done    = (state == S_DONE);
  assign cur     = lat[y][x];
  assign rd_spin = lat[rd_y][rd_x];

  // Periodic neighbour coordinates of the current site.
  assign x_l = (x == '0) ? XW'(WIDTH - 1) : x - XW'(1);
  assign x_r = (x == XW'(WIDTH - 1)) ? '0 : x + XW'(1);
  assign y_t = (y == '0) ? YW'(HEIGHT - 1) : y - YW'(1);
  assign y_b = (y == YW'(HEIGHT - 1)) ? '0 : y + YW'(1);

  assign upd.upd_enable = run;
  assign upd.upd_spin   = run & cur;
  assign upd.upd_left   = run & lat[y][x_l];
  assign upd.upd_right  = run & lat[y][x_r];
  assign upd.upd_top    = run & lat[y_t][x];
  assign upd.upd_bottom = run & lat[y_b][x];
  assign upd.rand32     = rng;

  assign x_plus2      = {1'b0, x} + (XW + 1)'(2);
  assign row_end      = (x_plus2 >= (XW + 1)'(WIDTH));
  assign next_row_lsb = ~(y[0] ^ ph);

  // Checkerboard walk: step x by 2, then next row, then odd phase, then wrap to a new sweep.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    x_nx      = x;
    y_nx      = y;
    ph_nx     = ph;
    sweep_end = 1'b0;
    if (!row_end) begin
      x_nx = x + XW'(2);
    end else if (y != YW'(HEIGHT - 1)) begin
      y_nx = y + YW'(1);
      x_nx = XW'(next_row_lsb);
    end else if (!ph) begin
      ph_nx = 1'b1;
      y_nx  = '0;
      x_nx  = XW'(1);
    end else begin
      ph_nx     = 1'b0;
      y_nx      = '0;
      x_nx      = '0;
      sweep_end = 1'b1;
    end
  end

  // Sequencer: state, site position, sweep counting.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    if (!rst_n) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      ph        <= 1'b0;
      nsw       <= '0;
      sweep_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sweep_cnt <= '0;
            nsw       <= num_sweeps;
            x         <= '0;
            y         <= '0;
            ph        <= 1'b0;
            if (num_sweeps == '0) state <= S_DONE;
            else if (init_up)     state <= S_INIT;
            else                  state <= S_RUN;
          end
        end
        S_INIT: state <= S_RUN;
        S_RUN: begin
          x  <= x_nx;
          y  <= y_nx;
          ph <= ph_nx;
          if (sweep_end) begin
            sweep_cnt <= sweep_cnt + SW_W'(1);
            if ((sweep_cnt + SW_W'(1)) == nsw) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Lattice storage and magnetization tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the lattice is a register array that must come out of reset all-up, so it is reset like any flop.
    if (!rst_n) begin
      lat <= '1;
      mag <= MAG_FULL;
    end else if (state == S_INIT) begin
      lat <= '1;
      mag <= MAG_FULL;
    end else if (run) begin
      lat[y][x] <= upd.upd_result;
      if (cur != upd.upd_result) begin
        mag <= upd.upd_result ? mag + MAG_W'(2) : mag - MAG_W'(2);
      end
    end
  end

  // Random word for the Spin cell; advances only while sites are being updated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rng <= SEED_EFF;
    else if (run) rng <= xorshift32(rng);
  end

endmodule

// File: tb/tb_spin_sweep_controller.sv
// Bench for spin_sweep_controller on a 4x4 lattice with a behavioural Spin cell.
// A lattice model and xorshift model predict every cycle of each run.
module tb_spin_sweep_controller;
  localparam int          W    = 4;
  localparam int          H    = 4;
  localparam logic [31:0] SEED = 32'hACE1_2025;

  localparam int M_FLIP = 0;
  localparam int M_KEEP = 1;
  localparam int M_RAND = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              init_up = 1'b0;
  logic [15:0]       num_sweeps = '0;
  logic              busy, done;
  logic [15:0]       sweep_cnt;
  logic signed [5:0] mag;
  logic [1:0]        rd_x = '0;
  logic [1:0]        rd_y = '0;
  logic              rd_spin;

  int mode = M_KEEP;
  bit rbit = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m [H][W];
  logic [31:0] m_rng;

  spin_sweep_controller_if ifc ();

  // Behavioural Spin cell: flip, keep, or a random coin per visit.
  assign ifc.upd_result = (mode == M_FLIP) ? ~ifc.upd_spin :
                          (mode == M_KEEP) ?  ifc.upd_spin : rbit;

  spin_sweep_controller #(
    .WIDTH (W),
    .HEIGHT(H),
    .SEED  (SEED),
    .SW_W  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .init_up   (init_up),
    .num_sweeps(num_sweeps),
    .busy      (busy),
    .done      (done),
    .sweep_cnt (sweep_cnt),
    .mag       (mag),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_spin   (rd_spin),
    .upd       (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xs_ref(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

  function automatic logic signed [5:0] model_mag();
    int sum;
    sum = 0;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        sum += m[yy][xx] ? 1 : -1;
    return 6'(sum);
  endfunction

  task automatic model_all_up();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        m[yy][xx] = 1'b1;
  endtask

  task automatic check_lattice(input string name);
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        rd_x = 2'(xx);
        rd_y = 2'(yy);
        #1;
        n_checks++;
        if (rd_spin !== m[yy][xx]) begin
          n_fail++;
          $display("FAIL %s site(%0d,%0d): got %b expected %b", name, xx, yy, rd_spin, m[yy][xx]);
        end
      end
    end
  endtask

  // Launch a run and check it cycle by cycle; poke_at >= 0 pulses a rogue start at that RUN cycle.
  task automatic run_sweeps(input string name, input int nsw, input bit init, input int md,
                            input int poke_at);
    int qx[$];
    int qy[$];
    int c;
    bit res;
    logic [5:0] obs, exp_v;
    logic signed [5:0] em;

    for (int p = 0; p < 2; p++)
      for (int yy = 0; yy < H; yy++)
        for (int xx = (yy + p) & 1; xx < W; xx += 2) begin
          qx.push_back(xx);
          qy.push_back(yy);
        end

    mode = md;
    @(negedge clk);
    start = 1'b1; num_sweeps = 16'(nsw); init_up = init;
    @(negedge clk);
    start = 1'b0; num_sweeps = 16'($urandom_range(0, 7)); init_up = 1'($urandom_range(0, 1));
    #1;

    if (nsw == 0) begin
      n_checks++;
      if ({done, busy, ifc.upd_enable} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s zero_done: got done/busy/en=%b expected 100", name, {done, busy, ifc.upd_enable});
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({done, busy, ifc.upd_enable} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s zero_idle: got done/busy/en=%b expected 000", name, {done, busy, ifc.upd_enable});
      end
      check_lattice({name, "_lattice"});
      return;
    end

    if (init) begin
      n_checks++;
      if ({done, busy, ifc.upd_enable} !== 3'b010) begin
        n_fail++;
        $display("FAIL %s init_cycle: got done/busy/en=%b expected 010", name, {done, busy, ifc.upd_enable});
      end
      model_all_up();
      @(negedge clk);
      #1;
    end

    c = 0;
    for (int s = 0; s < nsw; s++) begin
      for (int i = 0; i < W * H; i++) begin
        int sx, sy;
        sx = qx[i];
        sy = qy[i];
        rbit = 1'($urandom_range(0, 1));
        #1;
        obs   = {ifc.upd_enable, ifc.upd_spin, ifc.upd_left, ifc.upd_right, ifc.upd_top, ifc.upd_bottom};
        exp_v = {1'b1, m[sy][sx], m[sy][(sx + W - 1) % W], m[sy][(sx + 1) % W],
                 m[(sy + H - 1) % H][sx], m[(sy + 1) % H][sx]};
        n_checks++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL %s site_io s%0d i%0d (%0d,%0d): got en/s/l/r/t/b=%b expected %b",
                   name, s, i, sx, sy, obs, exp_v);
        end
        n_checks++;
        if (ifc.rand32 !== m_rng) begin
          n_fail++;
          $display("FAIL %s rand32 s%0d i%0d: got %h expected %h", name, s, i, ifc.rand32, m_rng);
        end
        em = model_mag();
        n_checks++;
        if ({busy, done, sweep_cnt, mag} !== {1'b1, 1'b0, 16'(s), em}) begin
          n_fail++;
          $display("FAIL %s status s%0d i%0d: got busy=%b done=%b cnt=%0d mag=%0d expected 1 0 %0d %0d",
                   name, s, i, busy, done, sweep_cnt, mag, s, em);
        end
        res = (md == M_FLIP) ? ~m[sy][sx] : (md == M_KEEP) ? m[sy][sx] : rbit;
        m[sy][sx] = res;
        m_rng = xs_ref(m_rng);
        if (c == poke_at) begin
          start = 1'b1; init_up = 1'b1; num_sweeps = '0;
        end else begin
          start = 1'b0;
        end
        c++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    #1;
    em = model_mag();
    n_checks++;
    if ({done, busy, ifc.upd_enable, ifc.upd_spin} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s done_cycle: got done/busy/en/spin=%b expected 1000", name,
               {done, busy, ifc.upd_enable, ifc.upd_spin});
    end
    n_checks++;
    if ({sweep_cnt, mag} !== {16'(nsw), em}) begin
      n_fail++;
      $display("FAIL %s done_status: got cnt=%0d mag=%0d expected %0d %0d", name, sweep_cnt, mag, nsw, em);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({done, busy, sweep_cnt} !== {1'b0, 1'b0, 16'(nsw)}) begin
      n_fail++;
      $display("FAIL %s idle_hold: got done=%b busy=%b cnt=%0d expected 0 0 %0d", name, done, busy, sweep_cnt, nsw);
    end
    check_lattice({name, "_lattice"});
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if ({busy, done, ifc.upd_enable, ifc.upd_spin, ifc.upd_left, ifc.upd_right, ifc.upd_top, ifc.upd_bottom} !== 8'h00) begin
      n_fail++;
      $display("FAIL %s outputs: got busy/done/en/s/l/r/t/b=%b expected 00000000", name,
               {busy, done, ifc.upd_enable, ifc.upd_spin, ifc.upd_left, ifc.upd_right, ifc.upd_top, ifc.upd_bottom});
    end
    n_checks++;
    if ({sweep_cnt, mag, ifc.rand32} !== {16'd0, 6'sd16, SEED}) begin
      n_fail++;
      $display("FAIL %s status: got cnt=%0d mag=%0d rand=%h expected 0 16 %h", name, sweep_cnt, mag, ifc.rand32, SEED);
    end
    check_lattice({name, "_lattice"});
  endtask

  task automatic test_reset();
    model_all_up();
    m_rng = SEED;
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_values("reset");
  endtask

  task automatic test_flip_single();
    run_sweeps("flip_single", 1, 1'b0, M_FLIP, -1);
  endtask

  task automatic test_random_mix();
    run_sweeps("random_mix", 2, 1'b0, M_RAND, -1);
  endtask

  task automatic test_keep_order();
    run_sweeps("keep_order", 1, 1'b0, M_KEEP, -1);
  endtask

  task automatic test_flip_two_init();
    run_sweeps("flip_two_init", 2, 1'b1, M_FLIP, -1);
  endtask

  task automatic test_ignore_start();
    run_sweeps("ignore_start", 2, 1'b0, M_RAND, 5);
  endtask

  task automatic test_abort();
    mode = M_FLIP;
    @(negedge clk);
    start = 1'b1; num_sweeps = 16'd2; init_up = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_all_up();
    m_rng = SEED;
    check_reset_values("abort");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_sweeps();
    run_sweeps("zero_premix", 1, 1'b0, M_RAND, -1);
    run_sweeps("zero_sweeps", 0, 1'b1, M_KEEP, -1);
    run_sweeps("init_after_mix", 1, 1'b1, M_KEEP, -1);
  endtask

  initial begin
    test_reset();
    test_flip_single();
    test_random_mix();
    test_keep_order();
    test_flip_two_init();
    test_ignore_start();
    test_abort();
    test_zero_sweeps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
